// File: rtl/mem_pkg.sv
// mem_pkg: shared types and legality limits for param_mem.
//   mem_state_t  : controller state (INIT sweep, READY for traffic)
//   RD_LAT_MIN/MAX : legal range of the read pipeline latency
//   params_legal : elaboration-time check used by param_mem
package mem_pkg;

    typedef enum logic {
        INIT,
        READY
    } mem_state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    // True when the data width is whole bytes and the read latency is in range.
    function automatic logic params_legal(input int unsigned data_w,
                                          input int unsigned rd_lat);
        return ((data_w % 8) == 0) && (data_w != 0) &&
               (rd_lat >= RD_LAT_MIN) && (rd_lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: STAGES-deep data/valid delay line for the param_mem read path.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high flush of all stages
//   in_valid  : read launched this cycle
//   in_data   : word read from the array (already collision-resolved)
//   out_valid : in_valid delayed by STAGES edges
//   out_data  : in_data delayed by STAGES edges
// With STAGES = 0 the block is a plain pass-through.
module mem_rd_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    if (STAGES == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign out_valid      = in_valid;
        assign out_data       = in_data;
    end else begin : g_pipe
        logic [STAGES-1:0] vld;
        logic [DATA_W-1:0] dat [STAGES];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
                for (int unsigned i = 0; i < STAGES; i++) begin
                    dat[i] <= '0;
                end
            end else begin
                vld[0] <= in_valid;
                dat[0] <= in_data;
                for (int unsigned i = 1; i < STAGES; i++) begin
                    vld[i] <= vld[i-1];
                    dat[i] <= dat[i-1];
                end
            end
        end

        assign out_valid = vld[STAGES-1];
        assign out_data  = dat[STAGES-1];
    end

endmodule

// File: rtl/param_mem.sv
// param_mem: parametrised single-port synchronous memory with byte enables,
// configurable read latency, selectable collision mode, a self-clearing
// init sweep after reset, busy indication and a sticky error flag.
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   read_enable  : read request
//   write_enable : write request
//   addr         : word address (shared by read and write)
//   data_in      : write data
//   byte_en      : per-byte write enable, bit i covers data_in[8i+7:8i]
//   data_out     : read data, held between reads
//   valid_out    : one-cycle pulse when data_out is new
//   busy         : high in reset and during the init sweep
//   err          : sticky; set by requests during busy or out-of-range addresses
module param_mem
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WRITE_FIRST = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_enable,
    input  logic                write_enable,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   data_out,
    output logic                valid_out,
    output logic                busy,
    output logic                err
);

    localparam int unsigned NBYTES = DATA_W / 8;

    if (!params_legal(DATA_W, RD_LAT)) begin : g_bad_params
        $error("param_mem: DATA_W must be a multiple of 8 and RD_LAT within 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    mem_state_t        state;
    logic [ADDR_W-1:0] ptr;

    logic              in_range;
    logic              wr_go;
    logic              rd_go;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    assign in_range = (32'(addr) < DEPTH);
    assign wr_go    = (state == READY) && write_enable && in_range;
    assign rd_go    = (state == READY) && read_enable;

    // Out-of-range reads see an all-zero word; since wr_go is also low then,
    // the collision path below can never forward data for them either.
    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem[addr];
        end
    end

    always_comb begin
        merged = old_word;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // Single port: a read and a write in the same cycle always share addr,
    // so the collision case is simply "write also accepted this cycle".
    always_comb begin
        rd_word = old_word;
        if ((WRITE_FIRST != 0) && wr_go) begin
            rd_word = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[ptr] <= '0;
        end else if (wr_go) begin
            mem[addr] <= merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            ptr   <= '0;
            busy  <= 1'b1;
            err   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (read_enable || write_enable) begin
                        err <= 1'b1;
                    end
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                READY: begin
                    if ((read_enable || write_enable) && !in_range) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= INIT;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LAT - 1)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_go),
        .in_data   (rd_word),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    // The output register supplies the final stage of latency and the hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pipe_valid;
            if (pipe_valid) begin
                data_out <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_param_mem.sv
// tb_param_mem: directed bench for param_mem. Five instances share one
// stimulus bus: DEPTH 16 with RD_LAT 1..4 (alternating collision mode) and a
// DEPTH 12 instance for out-of-range behaviour.
module tb_param_mem;

    localparam int N = 5;
    localparam int unsigned DEP [N] = '{16, 16, 16, 16, 12};
    localparam int unsigned LAT [N] = '{1, 2, 3, 4, 1};
    localparam int unsigned WF  [N] = '{0, 1, 0, 1, 0};
    localparam int CAP = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  byte_en = '0;

    logic [31:0] dout [N];
    logic        vout [N];
    logic        busy [N];
    logic        err  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        param_mem #(
            .DATA_W      (32),
            .DEPTH       (DEP[g]),
            .ADDR_W      (4),
            .RD_LAT      (LAT[g]),
            .WRITE_FIRST (WF[g])
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .read_enable  (read_enable),
            .write_enable (write_enable),
            .addr         (addr),
            .data_in      (data_in),
            .byte_en      (byte_en),
            .data_out     (dout[g]),
            .valid_out    (vout[g]),
            .busy         (busy[g]),
            .err          (err[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid pulse with the edge count at which it appeared.
    logic [31:0] cap_data [N][CAP];
    int          cap_cyc  [N][CAP];
    int          cap_n    [N] = '{default: 0};

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (vout[g] && cap_n[g] < CAP) begin
                cap_data[g][cap_n[g]] = dout[g];
                cap_cyc[g][cap_n[g]]  = cyc;
                cap_n[g]              = cap_n[g] + 1;
            end
        end
    end

    logic [31:0] model [16];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        addr = 4'(a); data_in = d; byte_en = be; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        for (int b = 0; b < 4; b++) if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    endtask

    // Back-to-back reads of a0..a0+n-1; checks count, data and arrival edge.
    task automatic rd_burst(input int a0, input int n, input string name);
        int base [N];
        int c0;
        logic [31:0] exp;
        for (int g = 0; g < N; g++) base[g] = cap_n[g];
        c0 = cyc;
        for (int i = 0; i < n; i++) begin
            addr = 4'(a0 + i); read_enable = 1'b1;
            tick();
        end
        read_enable = 1'b0;
        repeat (6) tick();
        for (int g = 0; g < N; g++) begin
            check($sformatf("%s_cnt%0d", name, g), 32'(cap_n[g] - base[g]), 32'(n));
            for (int i = 0; i < n && base[g] + i < CAP; i++) begin
                exp = (32'(a0 + i) >= DEP[g]) ? 32'h0 : model[a0 + i];
                check($sformatf("%s_dat%0d[%0d]", name, g, i), cap_data[g][base[g] + i], exp);
                check($sformatf("%s_lat%0d[%0d]", name, g, i), 32'(cap_cyc[g][base[g] + i]),
                      32'(c0 + i + int'(LAT[g])));
            end
        end
    endtask

    // Counts edges until busy falls; 'already' edges have elapsed since release.
    task automatic init_wait(input int already, input string name);
        int done [N];
        for (int g = 0; g < N; g++) done[g] = 0;
        for (int n = already + 1; n <= 24; n++) begin
            tick();
            for (int g = 0; g < N; g++) if (!busy[g] && done[g] == 0) done[g] = n;
        end
        for (int g = 0; g < N; g++)
            check($sformatf("%s_len%0d", name, g), 32'(done[g]), 32'(DEP[g]));
    endtask

    initial begin
        int base [N];
        for (int a = 0; a < 16; a++) model[a] = '0;

        // Reset state
        repeat (2) tick();
        for (int g = 0; g < N; g++) begin
            check($sformatf("rst_busy%0d", g), 32'(busy[g]), 32'd1);
            check($sformatf("rst_dout%0d", g), dout[g], 32'h0);
            check($sformatf("rst_vout%0d", g), 32'(vout[g]), 32'd0);
            check($sformatf("rst_err%0d", g), 32'(err[g]), 32'd0);
        end
        rst = 1'b0;
        init_wait(0, "init");
        for (int g = 0; g < N; g++) check($sformatf("init_err%0d", g), 32'(err[g]), 32'd0);

        // Every address reads zero after the sweep (12..15 out of range for DEPTH 12)
        rd_burst(0, 16, "clr");
        for (int g = 0; g < N; g++)
            check($sformatf("clr_err%0d", g), 32'(err[g]), (g == 4) ? 32'd1 : 32'd0);

        // Latency sweep with preloaded pattern
        for (int a = 0; a < 16; a++) wr(a, 32'(a) * 32'h01010101, 4'hF);
        rd_burst(0, 16, "lat");

        // Byte enables
        wr(3, 32'hAABBCCDD, 4'b1111);
        wr(3, 32'h11223344, 4'b0101);
        rd_burst(3, 1, "be");
        check("be_hand", cap_data[0][cap_n[0] - 1], 32'hAA22CC44);

        // Collision on addr 5
        wr(5, 32'h0, 4'hF);
        for (int g = 0; g < N; g++) base[g] = cap_n[g];
        addr = 4'd5; data_in = 32'hDEADBEEF; byte_en = 4'hF;
        write_enable = 1'b1; read_enable = 1'b1;
        tick();
        write_enable = 1'b0; read_enable = 1'b0;
        repeat (6) tick();
        for (int g = 0; g < N; g++) begin
            check($sformatf("col_cnt%0d", g), 32'(cap_n[g] - base[g]), 32'd1);
            check($sformatf("col_dat%0d", g), cap_data[g][base[g]],
                  (WF[g] != 0) ? 32'hDEADBEEF : 32'h0);
        end
        model[5] = 32'hDEADBEEF;
        rd_burst(5, 1, "colpost");

        // Out-of-range write to 13 (only DEPTH 12 drops it)
        wr(13, 32'h13131313, 4'hF);
        rd_burst(13, 1, "oor");
        check("oor_err4", 32'(err[4]), 32'd1);

        // Reset one cycle after a read of addr 2
        for (int g = 0; g < N; g++) base[g] = cap_n[g];
        addr = 4'd2; read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        for (int g = 0; g < N; g++) begin
            if (LAT[g] >= 2)
                check($sformatf("mid_novalid%0d", g), 32'(cap_n[g] - base[g]), 32'd0);
            check($sformatf("mid_dout%0d", g), dout[g], 32'h0);
            check($sformatf("mid_busy%0d", g), 32'(busy[g]), 32'd1);
            check($sformatf("mid_err%0d", g), 32'(err[g]), 32'd0);
        end
        for (int a = 0; a < 16; a++) model[a] = '0;

        // Release, and immediately issue a write while busy
        rst = 1'b0;
        addr = 4'd0; data_in = 32'hFFFFFFFF; byte_en = 4'hF; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        for (int g = 0; g < N; g++) check($sformatf("busy_err%0d", g), 32'(err[g]), 32'd1);
        init_wait(1, "reinit");
        rd_burst(0, 16, "reclr");
        for (int g = 0; g < N; g++) check($sformatf("sticky_err%0d", g), 32'(err[g]), 32'd1);

        // Only reset clears err
        rst = 1'b1;
        tick();
        for (int g = 0; g < N; g++) check($sformatf("errclr%0d", g), 32'(err[g]), 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
